osd_reg_initiator: RTL
======================

# osd_reg_initiator

Register-access initiator for the debug interconnect: accepts one 16-bit register read or write command on a valid/ready port, serializes it into a DII register-request packet toward a destination module, then waits for and decodes the matching response packet. It sits on the host/debug-master side of the ring, opposite the per-module register-access responders such as the subnet control module. A timeout guarantees a response even when the target never answers.

## Interface

- `TIMEOUT`, 1024: cycles to wait for a response after the last request flit; 0 disables the timeout.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `id`  in  10  own DII address; sent as the source flit, zero-extended to 16 bits.
- `req_valid`  in  1  command valid.
- `req_ready`  out  1  command accepted when both are high.
- `req_write`  in  1  1 = write, 0 = read.
- `req_dest`  in  16  destination module address.
- `req_addr`  in  16  register address.
- `req_wdata`  in  16  write data.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response consumed when both are high.
- `rsp_err`  out  1  error response or timeout.
- `rsp_timeout`  out  1  response was produced by the timeout.
- `rsp_rdata`  out  16  read data; 0 for writes and errors.
- `debug_out`  out  dii_flit  request flits.
- `debug_out_ready`  in  1  downstream accepts a flit.
- `debug_in`  in  dii_flit  incoming flits.
- `debug_in_ready`  out  1  flit accepted.

## Operation

- Header flit layout: TYPE[15:14] = 2'b00 (REG), TYPE_SUB[13:10], bits [9:0] = 0.
- Subtypes:
  - REQ_READ_16 = 4'b0000.
  - REQ_WRITE_16 = 4'b0100.
  - RESP_READ_OK_16 = 4'b1000.
  - RESP_READ_ERR = 4'b1100.
  - RESP_WRITE_OK = 4'b1110.
  - RESP_WRITE_ERR = 4'b1111.
- Command transfer: `req_write`, `req_dest`, `req_addr`, `req_wdata` are registered when `req_valid & req_ready`.
- Main FSM: IDLE → TX_DEST → TX_SRC → TX_HDR → TX_ADDR → [TX_DATA, writes only] → WAIT → RSP → IDLE.
- TX states:
  - `debug_out.valid` = 1.
  - `debug_out.last` = 1 on TX_ADDR for reads and on TX_DATA for writes.
  - The state advances only when `debug_out_ready` is high.
- WAIT:
  - The timeout counter starts at 0 on entry and increments every cycle.
  - When it reaches `TIMEOUT - 1` with no match, go to RSP with `rsp_err` = 1 and `rsp_timeout` = 1.
- RSP: hold `rsp_valid` = 1 until `rsp_ready`, then return to IDLE.
- RX parser: independent 5-flit indexer (DEST, SRC, HDR, DATA, DROP) that runs in every main state. `debug_in_ready` = 1 in every state except RSP.
- A packet matches only if all of the following hold:
  - Main state is WAIT.
  - dest flit == `{6'b0, id}` and src flit == the registered `req_dest`.
  - TYPE == REG.
  - TYPE_SUB is a response of the issued kind.
  - Flit count is correct: 3 flits for RESP_READ_ERR and both write responses, 4 flits for RESP_READ_OK_16.
- On the matching `last` flit:
  - Latch `rsp_err` = 1 for the *_ERR subtypes.
  - Latch `rsp_rdata` = data flit for RESP_READ_OK_16.
  - Go to RSP.
- Non-matching packets are consumed to `last` and discarded. Examples: wrong src, wrong type, arriving in IDLE/TX, or arriving after a timeout.
- Packets with extra flits are consumed and discarded.

## Timing

- Reset values:
  - Main FSM = IDLE, RX parser = DEST, counter = 0.
  - `debug_out.valid` = 0, `rsp_valid` = 0, `rsp_err` = 0, `rsp_timeout` = 0, `rsp_rdata` = 0.
  - `req_ready` = 1, `debug_in_ready` = 1.
- `req_ready` = (state == IDLE), combinational.
- `debug_out` and `rsp_*` are driven from registered state only; there is no combinational path from `debug_in` or `req_*`.
- Command accepted in cycle 0 → dest flit valid in cycle 1. With `debug_out_ready` held high, the last flit is in cycle 4 (read) or cycle 5 (write).
- Matching `last` flit accepted in cycle n → `rsp_valid` in cycle n+1.
- Back-to-back: `rsp_ready` in cycle m → `req_ready` in cycle m+1.
- Simultaneous timeout expiry and matching `last` flit in the same cycle: the real response wins (`rsp_timeout` = 0).
- `rst` asserted mid-packet, in any state: all state clears immediately. Any partial packet on `debug_out` is abandoned.

## Test plan

- Read, id = 0x001, dest = 0x005, addr = 0x0200 → flits 0x0005, 0x0001, 0x0000, 0x0200 (last). Reply 0x0001, 0x0005, 0x2000, 0xBEEF (last) → `rsp_rdata` = 0xBEEF, `rsp_err` = 0.
- Write, addr = 0x0204, data = 0x0003 → five flits, header 0x1000, last on 0x0003. Reply header 0x3800 → `rsp_err` = 0, `rsp_rdata` = 0.
- Read to a bad address, reply header 0x3000 (3 flits) → `rsp_err` = 1, `rsp_timeout` = 0.
- `TIMEOUT` = 16, no reply → `rsp_valid` 16 cycles after WAIT entry with `rsp_err` = 1 and `rsp_timeout` = 1. A late reply is then drained with no second response.
- Toggle `debug_out_ready` randomly and inject a foreign packet (src 0x0009) during WAIT → request flits stay intact, the foreign packet is dropped, and the correct reply is still matched.
- Assert `rst` during TX_ADDR → `debug_out.valid` = 0 and `req_ready` = 1 after release. The next command produces a clean packet.

Source files
------------

// File: rtl/osd_reg_initiator.sv
// Register-access initiator: turns one 16-bit register read/write command into a DII request
// packet, then waits for the matching response packet or a timeout.
module osd_reg_initiator #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  id,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_dest,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic [15:0] rsp_rdata,
  output logic        debug_out_valid,
  output logic        debug_out_last,
  output logic [15:0] debug_out_data,
  input  logic        debug_out_ready,
  input  logic        debug_in_valid,
  input  logic        debug_in_last,
  input  logic [15:0] debug_in_data,
  output logic        debug_in_ready
);

  localparam logic [1:0] TypeReg        = 2'b00;
  localparam logic [3:0] SubReqRead16   = 4'b0000;
  localparam logic [3:0] SubReqWrite16  = 4'b0100;
  localparam logic [3:0] SubRespReadOk  = 4'b1000;
  localparam logic [3:0] SubRespReadErr = 4'b1100;
  localparam logic [3:0] SubRespWriteOk = 4'b1110;
  localparam logic [3:0] SubRespWriteErr = 4'b1111;

  localparam int unsigned     CntW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle, StTxDest, StTxSrc, StTxHdr, StTxAddr, StTxData, StWait, StRsp
  } state_e;

  typedef enum logic [2:0] {
    RxDest, RxSrc, RxHdr, RxData, RxDrop
  } rx_e;

  state_e          state_q, state_d;
  rx_e             rx_q, rx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            write_q, write_d;
  logic [15:0]     dest_q, dest_d;
  logic [15:0]     addr_q, addr_d;
  logic [15:0]     wdata_q, wdata_d;
  logic            rsp_err_q, rsp_err_d;
  logic            rsp_timeout_q, rsp_timeout_d;
  logic [15:0]     rsp_rdata_q, rsp_rdata_d;
  logic            pkt_ok_q, pkt_ok_d;
  logic [3:0]      sub_q, sub_d;

  logic       in_fire;
  logic       in_wait;
  logic       flit_ok;
  logic       pkt_ok;
  logic [3:0] sub;
  logic       kind_ok;
  logic       rx_match;
  logic       rx_is_err;

  // Outputs decode registered state only.
  always_comb begin
    req_ready       = (state_q == StIdle);
    debug_in_ready  = (state_q != StRsp);
    rsp_valid       = (state_q == StRsp);
    rsp_err         = rsp_err_q;
    rsp_timeout     = rsp_timeout_q;
    rsp_rdata       = rsp_rdata_q;
    debug_out_valid = 1'b0;
    debug_out_last  = 1'b0;
    debug_out_data  = 16'h0000;
    case (state_q)
      StTxDest: begin
        debug_out_valid = 1'b1;
        debug_out_data  = dest_q;
      end
      StTxSrc: begin
        debug_out_valid = 1'b1;
        debug_out_data  = {6'b0, id};
      end
      StTxHdr: begin
        debug_out_valid = 1'b1;
        debug_out_data  = {TypeReg, (write_q ? SubReqWrite16 : SubReqRead16), 10'b0};
      end
      StTxAddr: begin
        debug_out_valid = 1'b1;
        debug_out_last  = ~write_q;
        debug_out_data  = addr_q;
      end
      StTxData: begin
        debug_out_valid = 1'b1;
        debug_out_last  = 1'b1;
        debug_out_data  = wdata_q;
      end
      default: begin
        debug_out_valid = 1'b0;
      end
    endcase
  end

  // RX parser: tracks the flit index of every incoming packet and whether it can still match.
  always_comb begin
    in_fire = debug_in_valid & debug_in_ready;
    in_wait = (state_q == StWait);
    flit_ok = 1'b0;
    case (rx_q)
      RxDest:  flit_ok = in_wait && (debug_in_data == {6'b0, id});
      RxSrc:   flit_ok = in_wait && (debug_in_data == dest_q);
      RxHdr:   flit_ok = in_wait && (debug_in_data[15:14] == TypeReg);
      RxData:  flit_ok = in_wait;
      default: flit_ok = 1'b0;
    endcase
    pkt_ok = flit_ok && ((rx_q == RxDest) || pkt_ok_q);
    sub    = (rx_q == RxHdr) ? debug_in_data[13:10] : sub_q;

    // The flit index at `last` doubles as the packet-length check.
    kind_ok = 1'b0;
    if (rx_q == RxHdr) begin
      kind_ok = write_q ? ((sub == SubRespWriteOk) || (sub == SubRespWriteErr))
                        : (sub == SubRespReadErr);
    end else if (rx_q == RxData) begin
      kind_ok = ~write_q && (sub == SubRespReadOk);
    end
    rx_match  = in_fire && debug_in_last && pkt_ok && kind_ok;
    rx_is_err = (sub == SubRespReadErr) || (sub == SubRespWriteErr);

    rx_d     = rx_q;
    pkt_ok_d = pkt_ok_q;
    sub_d    = sub_q;
    if (in_fire) begin
      pkt_ok_d = pkt_ok;
      if (rx_q == RxHdr) begin
        sub_d = debug_in_data[13:10];
      end
      if (debug_in_last) begin
        rx_d = RxDest;
      end else begin
        case (rx_q)
          RxDest:  rx_d = RxSrc;
          RxSrc:   rx_d = RxHdr;
          RxHdr:   rx_d = RxData;
          default: rx_d = RxDrop;
        endcase
      end
    end
  end

  // Main FSM next state.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    write_d       = write_q;
    dest_d        = dest_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    rsp_rdata_d   = rsp_rdata_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          write_d = req_write;
          dest_d  = req_dest;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = StTxDest;
        end
      end
      StTxDest: if (debug_out_ready) state_d = StTxSrc;
      StTxSrc:  if (debug_out_ready) state_d = StTxHdr;
      StTxHdr:  if (debug_out_ready) state_d = StTxAddr;
      StTxAddr: begin
        if (debug_out_ready) begin
          state_d = write_q ? StTxData : StWait;
          cnt_d   = '0;
        end
      end
      StTxData: begin
        if (debug_out_ready) begin
          state_d = StWait;
          cnt_d   = '0;
        end
      end
      StWait: begin
        // A real response in the expiry cycle takes priority over the timeout.
        if (rx_match) begin
          state_d       = StRsp;
          rsp_err_d     = rx_is_err;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = (rx_q == RxData) ? debug_in_data : 16'h0000;
        end else if ((TIMEOUT != 0) && (cnt_q == CntLast)) begin
          state_d       = StRsp;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = 16'h0000;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRsp: if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      rx_q          <= RxDest;
      cnt_q         <= '0;
      write_q       <= 1'b0;
      dest_q        <= 16'h0000;
      addr_q        <= 16'h0000;
      wdata_q       <= 16'h0000;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= 16'h0000;
      pkt_ok_q      <= 1'b0;
      sub_q         <= 4'h0;
    end else begin
      state_q       <= state_d;
      rx_q          <= rx_d;
      cnt_q         <= cnt_d;
      write_q       <= write_d;
      dest_q        <= dest_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_rdata_q   <= rsp_rdata_d;
      pkt_ok_q      <= pkt_ok_d;
      sub_q         <= sub_d;
    end
  end

endmodule
